// File: rtl/cory_demuxn_if.sv
// Handshake bundle for cory_demuxn: the master side is the producer, the select source and the channel consumers.
interface cory_demuxn_if #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int S = $clog2(M),
  parameter int L = 2
);
  logic           i_a_v;
  logic [N-1:0]   i_a_d;
  logic           o_a_r;
  logic           i_s_v;
  logic [S-1:0]   i_s_d;
  logic           o_s_r;
  logic [M-1:0]   o_z_v;
  logic [M*N-1:0] o_z_d;
  logic [M-1:0]   i_z_r;
  logic [M*L-1:0] o_lvl;

  modport master (
    output i_a_v, i_a_d, i_s_v, i_s_d, i_z_r,
    input  o_a_r, o_s_r, o_z_v, o_z_d, o_lvl
  );

  modport slave (
    input  i_a_v, i_a_d, i_s_v, i_s_d, i_z_r,
    output o_a_r, o_s_r, o_z_v, o_z_d, o_lvl
  );
endinterface

// File: rtl/cory_demuxn.sv
// Select-steered valid/ready demux into M channels, each with a Q-deep FIFO and occupancy readout.
// Optional sticky out-of-range select flag: define CORY_DEMUXN_ERR_EN.
module cory_demuxn #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int S = $clog2(M),
  parameter int Q = 2,
  parameter int L = (Q == 0) ? 1 : $clog2(Q + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  cory_demuxn_if.slave bus
`ifdef CORY_DEMUXN_ERR_EN
  ,
  output logic         o_err,
  output logic [S-1:0] o_err_sel
`endif
);
  logic [M-1:0]   hit;
  logic [M-1:0]   cr;
  logic [M-1:0]   push;
  logic [M-1:0]   z_v;
  logic [M*N-1:0] z_d;
  logic [M*L-1:0] lvl;
  logic           in_range;
  logic           sel_rdy;
  logic           acc;

  // Out-of-range selects are always ready so the beat is consumed and dropped.
  assign in_range = (32'(bus.i_s_d) < M);
  assign sel_rdy  = in_range ? |(hit & cr) : 1'b1;
  assign acc      = bus.i_a_v && bus.i_s_v && sel_rdy;

  assign bus.o_a_r = acc;
  assign bus.o_s_r = acc;
  assign bus.o_z_v = z_v;
  assign bus.o_z_d = z_d;
  assign bus.o_lvl = lvl;

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_ch
      assign hit[gi]  = (32'(bus.i_s_d) == gi);
      assign push[gi] = acc && hit[gi];

      if (Q > 0) begin : g_fifo
        localparam int PW = (Q > 1) ? $clog2(Q) : 1;

        logic [N-1:0]  mem [2**PW];
        logic [PW-1:0] wr_ptr_reg;
        logic [PW-1:0] rd_ptr_reg;
        logic [PW-1:0] wr_ptr_next;
        logic [PW-1:0] rd_ptr_next;
        logic [L-1:0]  cnt_reg;
        logic          pop;

        assign pop         = z_v[gi] && bus.i_z_r[gi];
        assign wr_ptr_next = (wr_ptr_reg == PW'(Q - 1)) ? '0 : wr_ptr_reg + PW'(1);
        assign rd_ptr_next = (rd_ptr_reg == PW'(Q - 1)) ? '0 : rd_ptr_reg + PW'(1);

        always_ff @(posedge clk) begin
          if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
          end else begin
            if (push[gi]) wr_ptr_reg <= wr_ptr_next;
            if (pop)      rd_ptr_reg <= rd_ptr_next;
            if (push[gi] && !pop)      cnt_reg <= cnt_reg + L'(1);
            else if (pop && !push[gi]) cnt_reg <= cnt_reg - L'(1);
          end
        end

        // Storage is not reset; occupancy alone decides what is visible.
        always_ff @(posedge clk) begin
          if (push[gi]) mem[wr_ptr_reg] <= bus.i_a_d;
        end

        // A pop in the same cycle does not free the slot, so full is purely registered.
        assign cr[gi]          = (cnt_reg != L'(Q));
        assign z_v[gi]         = (cnt_reg != '0);
        assign z_d[gi*N +: N]  = z_v[gi] ? mem[rd_ptr_reg] : '0;
        assign lvl[gi*L +: L]  = cnt_reg;
      end else begin : g_pass
        assign z_v[gi]         = bus.i_a_v && bus.i_s_v && hit[gi];
        assign z_d[gi*N +: N]  = z_v[gi] ? bus.i_a_d : '0;
        assign cr[gi]          = bus.i_z_r[gi];
        assign lvl[gi*L +: L]  = '0;
      end
    end
  endgenerate

`ifdef CORY_DEMUXN_ERR_EN
  logic         err_reg;
  logic [S-1:0] err_sel_reg;

  // Only the first offending select is kept; later ones leave the capture alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_reg     <= 1'b0;
      err_sel_reg <= '0;
    end else if (acc && !in_range && !err_reg) begin
      err_reg     <= 1'b1;
      err_sel_reg <= bus.i_s_d;
    end
  end

  assign o_err     = err_reg;
  assign o_err_sel = err_sel_reg;
`endif

`ifdef SIM
  always_ff @(posedge clk) begin
    if (reset_n && acc && !in_range)
      $display("cory_demuxn: warning, out-of-range select %0d dropped", bus.i_s_d);
  end
`endif
endmodule

// File: tb/tb_cory_demuxn.sv
// Bench for cory_demuxn: an M=8/Q=2 instance under a per-channel queue scoreboard, plus an M=6/Q=0 instance driven from a vector table.
module tb_cory_demuxn;
  localparam int N  = 8;
  localparam int M  = 8;
  localparam int S  = 3;
  localparam int Q  = 2;
  localparam int L  = 2;
  localparam int M0 = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mon_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cory_demuxn_if #(.N(N), .M(M),  .S(S), .L(L)) bus ();
  cory_demuxn_if #(.N(N), .M(M0), .S(S), .L(1)) bus0 ();

`ifdef CORY_DEMUXN_ERR_EN
  logic         err, err0;
  logic [S-1:0] err_sel, err0_sel;
`endif

  cory_demuxn #(.N(N), .M(M), .S(S), .Q(Q), .L(L)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
`ifdef CORY_DEMUXN_ERR_EN
    , .o_err(err), .o_err_sel(err_sel)
`endif
  );

  cory_demuxn #(.N(N), .M(M0), .S(S), .Q(0), .L(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
`ifdef CORY_DEMUXN_ERR_EN
    , .o_err(err0), .o_err_sel(err0_sel)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard: one queue of expected beats per channel, pushed on accept, popped on drain.
  logic [7:0] sb [M][$];

  always @(negedge clk) begin : mon
    bit exp_r;
    if (mon_en) begin
      exp_r = bus.i_a_v && bus.i_s_v && (sb[bus.i_s_d].size() < Q);
      chk("o_a_r", 64'(bus.o_a_r), 64'(exp_r));
      chk("o_s_r", 64'(bus.o_s_r), 64'(exp_r));
      for (int k = 0; k < M; k++) begin
        chk($sformatf("lvl%0d", k), 64'(bus.o_lvl[k*L +: L]), 64'(sb[k].size()));
        chk($sformatf("zv%0d", k), 64'(bus.o_z_v[k]), 64'(sb[k].size() != 0));
        chk($sformatf("zd%0d", k), 64'(bus.o_z_d[k*N +: N]),
            (sb[k].size() != 0) ? 64'(sb[k][0]) : 64'h0);
      end
      if (!reset_n) begin
        for (int k = 0; k < M; k++) sb[k].delete();
      end else begin
        for (int k = 0; k < M; k++)
          if (sb[k].size() != 0 && bus.i_z_r[k]) void'(sb[k].pop_front());
        if (exp_r) sb[bus.i_s_d].push_back(bus.i_a_d);
      end
    end
  end

  typedef struct {
    string      name;
    logic       a_v;
    logic       s_v;
    logic [2:0] s_d;
    logic [7:0] d;
    logic [5:0] z_r;
    logic       exp_r;
    logic [5:0] exp_zv;
  } vec_t;

  vec_t tab [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int sel, input logic [7:0] d);
    bus.i_a_v = v;
    bus.i_s_v = v;
    bus.i_s_d = 3'(sel);
    bus.i_a_d = d;
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    logic ok = 1'b0;
    drive(1'b1, sel, d);
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = bus.o_a_r;
      step();
    end
    chk("send_accept", 64'(ok), 64'h1);
    drive(1'b0, 0, 8'h00);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    logic [47:0] ezd;
    tab[0] = '{"q0_no_sel",   1'b1, 1'b0, 3'd2, 8'h11, 6'h3f, 1'b0, 6'h00};
    tab[1] = '{"q0_no_data",  1'b0, 1'b1, 3'd2, 8'h12, 6'h3f, 1'b0, 6'h00};
    tab[2] = '{"q0_ch2",      1'b1, 1'b1, 3'd2, 8'h22, 6'h3f, 1'b1, 6'h04};
    tab[3] = '{"q0_ch2_stall",1'b1, 1'b1, 3'd2, 8'h23, 6'h3b, 1'b0, 6'h04};
    tab[4] = '{"q0_oor7",     1'b1, 1'b1, 3'd7, 8'h55, 6'h00, 1'b1, 6'h00};
    tab[5] = '{"q0_oor6",     1'b1, 1'b1, 3'd6, 8'h66, 6'h00, 1'b1, 6'h00};
    tab[6] = '{"q0_ch5",      1'b1, 1'b1, 3'd5, 8'h5a, 6'h20, 1'b1, 6'h20};
    tab[7] = '{"q0_ch0_stall",1'b1, 1'b1, 3'd0, 8'h0f, 6'h3e, 1'b0, 6'h01};

    drive(1'b0, 0, 8'h00);
    bus.i_z_r  = '0;
    bus0.i_a_v = 1'b0; bus0.i_s_v = 1'b0; bus0.i_s_d = '0; bus0.i_a_d = '0; bus0.i_z_r = '0;
    reset_n = 1'b0;
    step();
    @(negedge clk);
    chk("rst_zv",  64'(bus.o_z_v), 64'h0);
    chk("rst_lvl", 64'(bus.o_lvl), 64'h0);
    chk("rst_zd",  64'(bus.o_z_d), 64'h0);
    chk("rst_r",   64'(bus.o_a_r), 64'h0);

    // Pass-through instance is combinational: apply each row and compare immediately.
    for (int i = 0; i < 8; i++) begin
      bus0.i_a_v = tab[i].a_v; bus0.i_s_v = tab[i].s_v; bus0.i_s_d = tab[i].s_d;
      bus0.i_a_d = tab[i].d;   bus0.i_z_r = tab[i].z_r;
      #1;
      for (int k = 0; k < M0; k++) ezd[k*8 +: 8] = tab[i].exp_zv[k] ? tab[i].d : 8'h00;
      chk({tab[i].name, "_r"},   64'(bus0.o_a_r), 64'(tab[i].exp_r));
      chk({tab[i].name, "_sr"},  64'(bus0.o_s_r), 64'(tab[i].exp_r));
      chk({tab[i].name, "_zv"},  64'(bus0.o_z_v), 64'(tab[i].exp_zv));
      chk({tab[i].name, "_zd"},  64'(bus0.o_z_d), 64'(ezd));
      chk({tab[i].name, "_lvl"}, 64'(bus0.o_lvl), 64'h0);
    end
    bus0.i_a_v = 1'b0; bus0.i_s_v = 1'b0;

    step();
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Basic routing: each channel is valid exactly one cycle after its beat.
    bus.i_z_r = '1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k, 8'(8'h10 + k));
      @(negedge clk);
      chk($sformatf("route_r%0d", k), 64'(bus.o_a_r), 64'h1);
      chk($sformatf("route_zv%0d", k), 64'(bus.o_z_v), (k == 0) ? 64'h0 : 64'(1 << (k - 1)));
      step();
    end
    drive(1'b0, 0, 8'h00);
    @(negedge clk);
    chk("route_zv_last", 64'(bus.o_z_v), 64'h80);
    step(); step();

    // Full channel 3, then a single-cycle drain.
    bus.i_z_r = 8'hF7;
    drive(1'b1, 3, 8'hA1); @(negedge clk); chk("full_r1", 64'(bus.o_a_r), 64'h1); step();
    drive(1'b1, 3, 8'hA2); @(negedge clk); chk("full_r2", 64'(bus.o_a_r), 64'h1); step();
    drive(1'b1, 3, 8'hA3); @(negedge clk);
    chk("full_r3", 64'(bus.o_a_r), 64'h0);
    chk("full_lvl2", 64'(bus.o_lvl[3*L +: L]), 64'h2);
    step();
    bus.i_z_r = 8'hFF; @(negedge clk);
    chk("full_nobypass", 64'(bus.o_a_r), 64'h0);
    chk("full_head", 64'(bus.o_z_d[3*N +: N]), 64'hA1);
    step();
    bus.i_z_r = 8'hF7; @(negedge clk);
    chk("full_r4", 64'(bus.o_a_r), 64'h1);
    chk("full_lvl1", 64'(bus.o_lvl[3*L +: L]), 64'h1);
    step();
    drive(1'b0, 0, 8'h00);
    bus.i_z_r = '1;
    @(negedge clk); chk("full_head2", 64'(bus.o_z_d[3*N +: N]), 64'hA2); step();
    @(negedge clk); chk("full_head3", 64'(bus.o_z_d[3*N +: N]), 64'hA3); step();
    step();

    // Simultaneous push and pop on channel 5.
    drive(1'b1, 5, 8'h50); step();
    for (int i = 1; i < 7; i++) begin
      drive(1'b1, 5, 8'(8'h50 + i));
      @(negedge clk);
      chk($sformatf("pp_lvl%0d", i), 64'(bus.o_lvl[5*L +: L]), 64'h1);
      chk($sformatf("pp_zd%0d", i), 64'(bus.o_z_d[5*N +: N]), 64'(8'h50 + i - 1));
      step();
    end
    drive(1'b0, 0, 8'h00);
    @(negedge clk); chk("pp_lvl_end", 64'(bus.o_lvl[5*L +: L]), 64'h1);
    step(); step();

    // Data valid without select must not move anything.
    bus.i_z_r = '0;
    bus.i_a_v = 1'b1; bus.i_s_v = 1'b0; bus.i_s_d = 3'd2; bus.i_a_d = 8'h2C;
    @(negedge clk);
    chk("hs_r", 64'(bus.o_a_r), 64'h0);
    chk("hs_sr", 64'(bus.o_s_r), 64'h0);
    step();
    bus.i_s_v = 1'b1;
    @(negedge clk);
    chk("hs_nopush", 64'(bus.o_lvl[2*L +: L]), 64'h0);
    chk("hs_r2", 64'(bus.o_a_r), 64'h1);
    step();
    drive(1'b0, 0, 8'h00);
    @(negedge clk); chk("hs_lvl", 64'(bus.o_lvl[2*L +: L]), 64'h1);
    step();
    bus.i_z_r = '1;
    step(); step();

    // Reset mid-stream with a beat presented during the reset cycle.
    bus.i_z_r = '0;
    send(0, 8'hC0); send(0, 8'hC1); send(1, 8'hD0); send(1, 8'hD1);
    reset_n = 1'b0;
    drive(1'b1, 4, 8'hEE);
    @(negedge clk); chk("rm_pre_lvl", 64'(bus.o_lvl), 64'h000A);
    step();
    reset_n = 1'b1;
    drive(1'b0, 0, 8'h00);
    bus.i_z_r = '1;
    @(negedge clk);
    chk("rm_zv", 64'(bus.o_z_v), 64'h0);
    chk("rm_lvl", 64'(bus.o_lvl), 64'h0);
    step();
    drive(1'b1, 6, 8'h77); step();
    drive(1'b0, 0, 8'h00);
    @(negedge clk);
    chk("rm_alone_zv", 64'(bus.o_z_v), 64'h40);
    chk("rm_alone_zd", 64'(bus.o_z_d), 64'h0077_0000_0000_0000);
    step(); step();

`ifdef CORY_DEMUXN_ERR_EN
    bus0.i_a_v = 1'b1; bus0.i_s_v = 1'b1; bus0.i_s_d = 3'd7; bus0.i_a_d = 8'h55;
    step();
    bus0.i_s_d = 3'd6;
    step();
    bus0.i_a_v = 1'b0; bus0.i_s_v = 1'b0;
    chk("err_flag", 64'(err0), 64'h1);
    chk("err_sel", 64'(err0_sel), 64'h7);
    chk("err_lvl", 64'(bus0.o_lvl), 64'h0);
    chk("err_main", 64'(err), 64'h0);
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
